mempool_cc_port_buffer: RTL and testbench
=========================================

// Module: mempool_cc_port_buffer
// PURPOSE
// - Parametrised buffer between a Snitch core complex and the TCDM interconnect; supersedes fixed single-port spill cuts.
// - Provides NumPorts independent request/response channels, each with configurable FIFO depth per direction.
// - Per-port outstanding-transaction tracking throttles requests at MaxOutstanding.
// - Flags spurious responses and reports per-port idle status for drain/sleep sequencing.
// PARAMETERS
// - NumPorts        1   number of independent TCDM channels
// - ReqDepth        2   request FIFO entries per port; 0 = combinational bypass
// - RespDepth       2   response FIFO entries per port; 0 = combinational bypass
// - MaxOutstanding  8   in-flight request limit per port (>=1)
// - AddrWidth/DataWidth/IdWidth  32/32/5   field widths; StrbWidth = DataWidth/8; CntW = $clog2(MaxOutstanding+1)
// PORTS (per-port signals are unpacked arrays [NumPorts])
// - clk_i            in   1     clock
// - rst_i            in   1     reset, synchronous, active-high
// - core_q{addr,write,amo,data,strb,id}_i  in  Addr/1/4/Data/Strb/Id  core request payload
// - core_qvalid_i / core_qready_o          in/out  1   core request handshake
// - core_p{data,error,id}_o / core_pvalid_o / core_pready_i  out/out/out/out/in  Data/1/Id/1/1  core response
// - mem_q{addr,write,amo,data,strb,id}_o / mem_qvalid_o / mem_qready_i  out/out/in  same widths  TCDM request
// - mem_p{data,error,id}_i / mem_pvalid_i / mem_pready_o  in/in/out  Data/1/Id/1/1  TCDM response
// - outstanding_o    out  CntW  in-flight requests per port
// - idle_o           out  1     per port: outstanding==0 and both FIFOs empty
// - spurious_o       out  1     per port, sticky: response received with outstanding==0
// - stall_cnt_o / throttle_cnt_o  out  32  per-port perf counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_i sampled high at posedge): FIFOs emptied, outstanding_o=0, spurious_o=0, perf counters=0;
//   outputs during/after reset: core_qready_o=1 (if ReqDepth>0), mem_qvalid_o=0, core_pvalid_o=0,
//   mem_pready_o=1 (if RespDepth>0), idle_o=1. Reset mid-transfer drops all buffered entries, no responses replayed.
// - Transfer occurs on valid&&ready; valid never depends on ready; payload held stable while valid&&!ready.
// - Request FIFO (Depth>0): core_qready_o = !full; entry visible at mem side the cycle after push (1-cycle latency);
//   push while full forbidden by ready; push and pop same cycle when not full/not empty both take effect; order preserved.
// - Response FIFO identical with roles swapped: mem_pready_o = !full; core_p* 1 cycle after push.
// - Depth==0: direct wires, zero latency, ready/valid combinationally forwarded.
// - Throttle: mem_qvalid_o = req_fifo_nonempty && (outstanding_o < MaxOutstanding); payload still presented.
// - Every request (load, store, AMO) expects exactly one response.
// - Outstanding counter: +1 on mem request handshake, -1 on mem response handshake, unchanged when both same cycle.
// - Counter saturates: response handshake at 0 leaves 0 and sets spurious_o; response still forwarded to core.
// - IDs/payload passed unchanged; no reordering, no ID remapping; ports fully independent (no shared arbitration).
// - idle_o combinational from registered state; stays 0 while any entry buffered or in flight.
// CONFIGURATION
// - Macro MEMPOOL_CC_PORT_BUFFER_PERF_EN:
//   defined: stall_cnt_o counts cycles core_qvalid_i && !core_qready_o; throttle_cnt_o counts cycles request FIFO
//     non-empty and outstanding_o==MaxOutstanding; both saturate at 32'hFFFF_FFFF, cleared only by reset.
//   undefined: no counter flops synthesised; stall_cnt_o and throttle_cnt_o tied to 0; port list unchanged.
// TESTING
// - Reset: hold rst_i 2 cycles mid-traffic -> next cycle outstanding_o=0, idle_o=1, mem_qvalid_o=0, spurious_o=0.
// - Throttle: MaxOutstanding=2, mem_pvalid_i=0, 4 back-to-back requests -> exactly 2 mem handshakes, outstanding_o=2,
//   mem_qvalid_o=0; one response -> third request issued the following cycle.
// - Backpressure: ReqDepth=2, mem_qready_i=0, 3 requests -> core_qready_o=0 after 2 pushes; stall_cnt_o increments
//   per blocked cycle (PERF_EN); release -> addrs 0x100,0x104,0x108 emerge in order.
// - Simultaneous: request and response handshake same cycle at outstanding_o=3 -> remains 3.
// - Spurious: response with outstanding_o=0, id=5, data=0xDEAD_BEEF -> spurious_o=1 (sticky), core sees id 5 data
//   0xDEADBEEF, outstanding_o stays 0.
// - Bypass/multi-port: NumPorts=4, ReqDepth=RespDepth=0, random traffic per port -> zero latency, per-port order and
//   counts match scoreboard, no cross-port interference.

Source files
------------

// File: rtl/mempool_cc_port_buffer_if.sv
// ---------------------------------------------------------------------------
// mempool_cc_port_buffer_if
// Purpose : multi-port TCDM request/response bundle. One instance carries all
//           NumPorts channels; every field is an unpacked array [NumPorts].
// Signals : q*      request payload (addr, write, amo, data, strb, id)
//           qvalid  request valid   (master -> slave)
//           qready  request ready   (slave  -> master)
//           p*      response payload (data, error, id)
//           pvalid  response valid  (slave  -> master)
//           pready  response ready  (master -> slave)
// Modports: master issues requests and accepts responses; slave is the
//           opposite side.
// ---------------------------------------------------------------------------
interface mempool_cc_port_buffer_if #(
    parameter int unsigned NumPorts  = 1,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 5
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [AddrWidth-1:0] qaddr  [NumPorts];
    logic                 qwrite [NumPorts];
    logic [3:0]           qamo   [NumPorts];
    logic [DataWidth-1:0] qdata  [NumPorts];
    logic [StrbWidth-1:0] qstrb  [NumPorts];
    logic [IdWidth-1:0]   qid    [NumPorts];
    logic                 qvalid [NumPorts];
    logic                 qready [NumPorts];

    logic [DataWidth-1:0] pdata  [NumPorts];
    logic                 perror [NumPorts];
    logic [IdWidth-1:0]   pid    [NumPorts];
    logic                 pvalid [NumPorts];
    logic                 pready [NumPorts];

    modport master (
        output qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
        input  qready, pdata, perror, pid, pvalid
    );

    modport slave (
        input  qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
        output qready, pdata, perror, pid, pvalid
    );
endinterface

// File: rtl/mempool_cc_port_buffer.sv
// ---------------------------------------------------------------------------
// mempool_cc_port_buffer
// Purpose : per-port buffer between a Snitch core complex and the TCDM
//           interconnect. Each of NumPorts channels has its own request and
//           response FIFO (depth 0 = combinational bypass), an outstanding-
//           request counter that throttles issue at MaxOutstanding, a sticky
//           spurious-response flag and an idle indication.
// Ports   : clk_i           clock
//           rst_i           synchronous active-high reset
//           core            slave side, faces the core complex
//           mem             master side, faces the TCDM interconnect
//           outstanding_o   in-flight requests per port
//           idle_o          nothing buffered and nothing in flight
//           spurious_o      sticky: response arrived with nothing in flight
//           stall_cnt_o     cycles a core request was refused
//           throttle_cnt_o  cycles a buffered request was held by the limit
// Option  : define MEMPOOL_CC_PORT_BUFFER_PERF_EN to build the two perf
//           counters; otherwise they read as zero and no flops are built.
// ---------------------------------------------------------------------------

// Ready/valid FIFO used for both directions. Depth 0 degenerates to wires.
module mempool_cc_port_buffer_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [Width-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [Width-1:0] pop_data_o,
    output logic             empty_o
);
    if (Depth == 0) begin : g_bypass
        assign pop_valid_o  = push_valid_i;
        assign push_ready_o = pop_ready_i;
        assign pop_data_o   = push_data_i;
        assign empty_o      = 1'b1;
    end else begin : g_fifo
        localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
        localparam int unsigned CntW = $clog2(Depth + 1);
        localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

        logic [Width-1:0] mem_q [Depth];
        logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
        logic [CntW-1:0]  count_q;
        logic             push, pop;

        assign push_ready_o = (count_q != CntW'(Depth));
        assign pop_valid_o  = (count_q != '0);
        assign empty_o      = (count_q == '0);
        assign pop_data_o   = mem_q[rd_ptr_q];
        assign push         = push_valid_i && push_ready_o;
        assign pop          = pop_valid_o && pop_ready_i;

        // NOTE: storage is deliberately not reset; the count alone decides
        // which entries are valid, so clearing the array would only add muxes.
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_ptr_q] <= push_data_i;
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
                count_q <= count_q + CntW'(push) - CntW'(pop);
            end
        end
    end
endmodule

module mempool_cc_port_buffer #(
    parameter int unsigned NumPorts       = 1,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned RespDepth      = 2,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 5
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    mempool_cc_port_buffer_if.slave               core,
    mempool_cc_port_buffer_if.master              mem,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o  [NumPorts],
    output logic                                  idle_o         [NumPorts],
    output logic                                  spurious_o     [NumPorts],
    output logic [31:0]                           stall_cnt_o    [NumPorts],
    output logic [31:0]                           throttle_cnt_o [NumPorts]
);
    localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [3:0]           amo;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic [IdWidth-1:0]   id;
    } req_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 error;
        logic [IdWidth-1:0]   id;
    } resp_t;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        req_t            req_in, req_out;
        resp_t           resp_in, resp_out;
        logic            req_push_ready, req_valid, req_pop_ready, req_empty;
        logic            resp_push_ready, resp_valid, resp_empty;
        logic            below_limit, mem_qvalid, mem_q_hs, mem_p_hs;
        logic [CntW-1:0] outstanding_q;
        logic            spurious_q;

        // ---------------- request path ----------------
        assign req_in = '{addr: core.qaddr[p], write: core.qwrite[p], amo: core.qamo[p],
                          data: core.qdata[p], strb: core.qstrb[p], id: core.qid[p]};

        mempool_cc_port_buffer_fifo #(.Depth(ReqDepth), .Width($bits(req_t))) i_req_fifo (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .push_valid_i (core.qvalid[p]),
            .push_ready_o (req_push_ready),
            .push_data_i  (req_in),
            .pop_valid_o  (req_valid),
            .pop_ready_i  (req_pop_ready),
            .pop_data_o   (req_out),
            .empty_o      (req_empty)
        );

        // The limit gates valid (not ready) so valid never depends on ready;
        // the payload keeps being presented while throttled.
        assign below_limit    = (outstanding_q < MaxCnt);
        assign mem_qvalid     = req_valid && below_limit;
        assign req_pop_ready  = mem.qready[p] && below_limit;
        assign core.qready[p] = req_push_ready;
        assign mem.qvalid[p]  = mem_qvalid;
        assign mem.qaddr[p]   = req_out.addr;
        assign mem.qwrite[p]  = req_out.write;
        assign mem.qamo[p]    = req_out.amo;
        assign mem.qdata[p]   = req_out.data;
        assign mem.qstrb[p]   = req_out.strb;
        assign mem.qid[p]     = req_out.id;

        // ---------------- response path ----------------
        assign resp_in = '{data: mem.pdata[p], error: mem.perror[p], id: mem.pid[p]};

        mempool_cc_port_buffer_fifo #(.Depth(RespDepth), .Width($bits(resp_t))) i_resp_fifo (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .push_valid_i (mem.pvalid[p]),
            .push_ready_o (resp_push_ready),
            .push_data_i  (resp_in),
            .pop_valid_o  (resp_valid),
            .pop_ready_i  (core.pready[p]),
            .pop_data_o   (resp_out),
            .empty_o      (resp_empty)
        );

        assign mem.pready[p]  = resp_push_ready;
        assign core.pvalid[p] = resp_valid;
        assign core.pdata[p]  = resp_out.data;
        assign core.perror[p] = resp_out.error;
        assign core.pid[p]    = resp_out.id;

        // ---------------- in-flight tracking ----------------
        assign mem_q_hs = mem_qvalid && mem.qready[p];
        assign mem_p_hs = mem.pvalid[p] && resp_push_ready;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                outstanding_q <= '0;
                spurious_q    <= 1'b0;
            end else begin
                // A response with nothing in flight is still forwarded; the
                // counter saturates at zero and the event is remembered.
                if (mem_p_hs && (outstanding_q == '0)) spurious_q <= 1'b1;
                case ({mem_q_hs, mem_p_hs})
                    2'b10:   outstanding_q <= outstanding_q + 1'b1;
                    2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - 1'b1;
                    default: outstanding_q <= outstanding_q;
                endcase
            end
        end

        assign outstanding_o[p] = outstanding_q;
        assign spurious_o[p]    = spurious_q;
        assign idle_o[p]        = (outstanding_q == '0) && req_empty && resp_empty;

        // ---------------- performance counters ----------------
`ifdef MEMPOOL_CC_PORT_BUFFER_PERF_EN
        logic [31:0] stall_q, throttle_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stall_q    <= '0;
                throttle_q <= '0;
            end else begin
                if (core.qvalid[p] && !req_push_ready && (stall_q != '1))
                    stall_q <= stall_q + 1'b1;
                if (req_valid && (outstanding_q == MaxCnt) && (throttle_q != '1))
                    throttle_q <= throttle_q + 1'b1;
            end
        end

        assign stall_cnt_o[p]    = stall_q;
        assign throttle_cnt_o[p] = throttle_q;
`else
        assign stall_cnt_o[p]    = '0;
        assign throttle_cnt_o[p] = '0;
`endif
    end
endmodule

// File: tb/tb_mempool_cc_port_buffer.sv
// ---------------------------------------------------------------------------
// tb_mempool_cc_port_buffer
// Two instances: "a" is a single buffered port with MaxOutstanding=2,
// "b" is four bypass ports with MaxOutstanding=8. Stimulus pushes expected
// responses into queues; monitors on the falling edge pop and compare.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mempool_cc_port_buffer;
    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance a ----------------
    mempool_cc_port_buffer_if #(.NumPorts(1)) core_a ();
    mempool_cc_port_buffer_if #(.NumPorts(1)) mem_a ();
    logic [1:0]  out_a   [1];
    logic        idle_a  [1];
    logic        spur_a  [1];
    logic [31:0] stall_a [1];
    logic [31:0] thr_a   [1];

    mempool_cc_port_buffer #(
        .NumPorts(1), .ReqDepth(2), .RespDepth(2), .MaxOutstanding(2)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .core(core_a), .mem(mem_a),
        .outstanding_o(out_a), .idle_o(idle_a), .spurious_o(spur_a),
        .stall_cnt_o(stall_a), .throttle_cnt_o(thr_a)
    );

    // ---------------- instance b ----------------
    mempool_cc_port_buffer_if #(.NumPorts(NB)) core_b ();
    mempool_cc_port_buffer_if #(.NumPorts(NB)) mem_b ();
    logic [3:0]  out_b   [NB];
    logic        idle_b  [NB];
    logic        spur_b  [NB];
    logic [31:0] stall_b [NB];
    logic [31:0] thr_b   [NB];

    mempool_cc_port_buffer #(
        .NumPorts(NB), .ReqDepth(0), .RespDepth(0), .MaxOutstanding(8)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .core(core_b), .mem(mem_b),
        .outstanding_o(out_b), .idle_o(idle_b), .spurious_o(spur_b),
        .stall_cnt_o(stall_b), .throttle_cnt_o(thr_b)
    );

    // ---------------- scoreboards ----------------
    logic [31:0] exp_req_a  [$];
    logic [36:0] exp_resp_a [$];   // {id, data}
    int          hs_a = 0;
    logic [31:0] exp_req_b  [NB][$];
    logic [31:0] exp_resp_b [NB][$];
    logic [31:0] pend_b     [NB][$];
    bit          b_resp_en = 1'b0;

    // Monitor for instance a.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mem_a.qvalid[0] && mem_a.qready[0]) begin
                hs_a++;
                check("a_req_expected", exp_req_a.size() != 0, 1);
                if (exp_req_a.size() != 0) check("a_req_addr", mem_a.qaddr[0], exp_req_a.pop_front());
            end
            if (core_a.pvalid[0] && core_a.pready[0]) begin
                check("a_resp_expected", exp_resp_a.size() != 0, 1);
                if (exp_resp_a.size() != 0)
                    check("a_resp_id_data", {core_a.pid[0], core_a.pdata[0]}, exp_resp_a.pop_front());
            end
        end
    end

    // Monitor for instance b, one scoreboard per port.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            for (int p = 0; p < NB; p++) begin
                if (mem_b.qvalid[p] && mem_b.qready[p]) begin
                    check("b_req_expected", exp_req_b[p].size() != 0, 1);
                    if (exp_req_b[p].size() != 0) check("b_req_addr", mem_b.qaddr[p], exp_req_b[p].pop_front());
                    pend_b[p].push_back(mem_b.qaddr[p]);
                end
                if (core_b.qvalid[p] && core_b.qready[p])
                    check("b_zero_latency", mem_b.qvalid[p] && mem_b.qready[p], 1);
                if (core_b.pvalid[p] && core_b.pready[p]) begin
                    check("b_resp_expected", exp_resp_b[p].size() != 0, 1);
                    if (exp_resp_b[p].size() != 0) check("b_resp_data", core_b.pdata[p], exp_resp_b[p].pop_front());
                end
            end
        end
    end

    // Memory model for instance b: answers each request with addr+1, in order.
    initial forever begin
        @(posedge clk);
        #1;
        if (b_resp_en) begin
            for (int p = 0; p < NB; p++) begin
                mem_b.pvalid[p] = 1'b0;
                if (pend_b[p].size() != 0 && $urandom_range(0, 1) == 1) begin
                    mem_b.pvalid[p] = 1'b1;
                    mem_b.pdata[p]  = pend_b[p].pop_front() + 32'd1;
                end
            end
        end
    end

    task automatic wait_core_hs_a(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (core_a.qvalid[0] && core_a.qready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        check(name, ok, 1);
    endtask

    task automatic push_b(input int p, input logic [31:0] addr);
        core_b.qvalid[p] = 1'b1;
        core_b.qaddr[p]  = addr;
        exp_req_b[p].push_back(addr);
        exp_resp_b[p].push_back(addr + 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          done;
        bit          hs [NB];
        int          sent [NB];
        logic [31:0] addr;

        core_a.qvalid[0] = 0; core_a.qaddr[0] = 0; core_a.qwrite[0] = 0; core_a.qamo[0] = 0;
        core_a.qdata[0] = 0; core_a.qstrb[0] = 0; core_a.qid[0] = 0; core_a.pready[0] = 1;
        mem_a.qready[0] = 0; mem_a.pvalid[0] = 0; mem_a.pdata[0] = 0; mem_a.perror[0] = 0; mem_a.pid[0] = 0;
        for (int p = 0; p < NB; p++) begin
            core_b.qvalid[p] = 0; core_b.qaddr[p] = 0; core_b.qwrite[p] = 0; core_b.qamo[p] = 0;
            core_b.qdata[p] = 0; core_b.qstrb[p] = 0; core_b.qid[p] = 0; core_b.pready[p] = 1;
            mem_b.qready[p] = 1; mem_b.pvalid[p] = 0; mem_b.pdata[p] = 0; mem_b.perror[p] = 0; mem_b.pid[p] = 0;
            sent[p] = 0;
        end

        // ---- reset state ----
        tick(); tick();
        rst = 1'b0;
        check("a_rst_qready", core_a.qready[0], 1);
        check("a_rst_mem_qvalid", mem_a.qvalid[0], 0);
        check("a_rst_core_pvalid", core_a.pvalid[0], 0);
        check("a_rst_mem_pready", mem_a.pready[0], 1);
        check("a_rst_idle", idle_a[0], 1);
        check("a_rst_outstanding", out_a[0], 0);
        check("a_rst_spurious", spur_a[0], 0);
        check("a_rst_stall", stall_a[0], 0);
        check("b_rst_idle", idle_b[2], 1);

        // ---- backpressure: 3 requests into a 2-deep FIFO ----
        core_a.qvalid[0] = 1; core_a.qaddr[0] = 32'h100; exp_req_a.push_back(32'h100);
        tick();
        core_a.qaddr[0] = 32'h104; exp_req_a.push_back(32'h104);
        tick();
        core_a.qaddr[0] = 32'h108; exp_req_a.push_back(32'h108);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_bp_qready", core_a.qready[0], 0);
            tick();
        end
`ifdef MEMPOOL_CC_PORT_BUFFER_PERF_EN
        check("a_stall_cnt_3", stall_a[0], 3);
`else
        check("a_stall_cnt_3", stall_a[0], 0);
`endif

        // ---- release, then throttle at MaxOutstanding=2 with a 4th request ----
        mem_a.qready[0] = 1;
        wait_core_hs_a("a_push_108");
        core_a.qaddr[0] = 32'h10C; exp_req_a.push_back(32'h10C);
        wait_core_hs_a("a_push_10c");
        core_a.qvalid[0] = 0;
        tick(); tick();
        check("a_thr_outstanding", out_a[0], 2);
        check("a_thr_mem_qvalid", mem_a.qvalid[0], 0);
        check("a_thr_handshakes", hs_a, 2);
        check("a_thr_idle", idle_a[0], 0);
`ifdef MEMPOOL_CC_PORT_BUFFER_PERF_EN
        check("a_throttle_cnt", thr_a[0], 3);
        check("a_stall_cnt_4", stall_a[0], 4);
`else
        check("a_throttle_cnt", thr_a[0], 0);
        check("a_stall_cnt_4", stall_a[0], 0);
`endif

        // One response frees a slot: the third request goes out next cycle.
        mem_a.pvalid[0] = 1; mem_a.pid[0] = 5'd3; mem_a.pdata[0] = 32'h1111_0000;
        exp_resp_a.push_back({5'd3, 32'h1111_0000});
        tick();
        mem_a.pvalid[0] = 0;
        @(negedge clk);
        check("a_third_issued", mem_a.qvalid[0], 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            mem_a.pvalid[0] = 1; mem_a.pid[0] = 5'(4 + k); mem_a.pdata[0] = 32'h2222_0000 + k;
            exp_resp_a.push_back({5'(4 + k), 32'h2222_0000 + 32'(k)});
            tick();
            mem_a.pvalid[0] = 0;
            tick();
        end
        repeat (6) tick();
        check("a_drain_outstanding", out_a[0], 0);
        check("a_drain_idle", idle_a[0], 1);
        check("a_drain_handshakes", hs_a, 4);
        check("a_drain_req_q", exp_req_a.size(), 0);
        check("a_drain_resp_q", exp_resp_a.size(), 0);

        // ---- spurious response ----
        mem_a.pvalid[0] = 1; mem_a.pid[0] = 5'd5; mem_a.pdata[0] = 32'hDEAD_BEEF;
        exp_resp_a.push_back({5'd5, 32'hDEAD_BEEF});
        tick();
        mem_a.pvalid[0] = 0;
        check("a_spurious_set", spur_a[0], 1);
        check("a_spurious_outstanding", out_a[0], 0);
        repeat (3) tick();
        check("a_spurious_sticky", spur_a[0], 1);
        check("a_spurious_resp_q", exp_resp_a.size(), 0);

        // ---- reset mid-traffic ----
        core_a.qvalid[0] = 1; core_a.qaddr[0] = 32'h200; exp_req_a.push_back(32'h200);
        wait_core_hs_a("a_push_200");
        core_a.qaddr[0] = 32'h204; exp_req_a.push_back(32'h204);
        wait_core_hs_a("a_push_204");
        core_a.qvalid[0] = 0;
        tick();
        mem_a.qready[0] = 0;
        core_a.qvalid[0] = 1; core_a.qaddr[0] = 32'h208;
        wait_core_hs_a("a_push_208");
        core_a.qvalid[0] = 0;
        check("a_pre_rst_outstanding", out_a[0], 2);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("a_midrst_outstanding", out_a[0], 0);
        check("a_midrst_idle", idle_a[0], 1);
        check("a_midrst_mem_qvalid", mem_a.qvalid[0], 0);
        check("a_midrst_spurious", spur_a[0], 0);
        check("a_midrst_qready", core_a.qready[0], 1);
        tick();

        // ---- b: request and response in the same cycle at outstanding=3 ----
        for (int k = 0; k < 3; k++) begin
            push_b(0, 32'(4 * k));
            tick();
        end
        core_b.qvalid[0] = 0;
        check("b_sim_before", out_b[0], 3);
        push_b(0, 32'hC);
        mem_b.pvalid[0] = 1; mem_b.pdata[0] = pend_b[0].pop_front() + 32'd1;
        tick();
        core_b.qvalid[0] = 0; mem_b.pvalid[0] = 0;
        check("b_sim_after", out_b[0], 3);
        check("b_sim_port1_idle", idle_b[1], 1);

        // ---- b: random per-port traffic ----
        b_resp_en = 1'b1;
        done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NB; p++) hs[p] = core_b.qvalid[p] && core_b.qready[p];
            tick();
            done = 1'b1;
            for (int p = 0; p < NB; p++) begin
                mem_b.qready[p] = ($urandom_range(0, 3) != 0);
                if (hs[p]) core_b.qvalid[p] = 1'b0;
                if (!core_b.qvalid[p] && sent[p] < 12 && $urandom_range(0, 1) == 1) begin
                    addr = 32'h1000 * 32'(p + 1) + 32'(4 * sent[p]);
                    push_b(p, addr);
                    sent[p]++;
                end
                if (sent[p] < 12 || core_b.qvalid[p]) done = 1'b0;
            end
        end
        check("b_traffic_done", done, 1);
        for (int p = 0; p < NB; p++) mem_b.qready[p] = 1;
        for (int n = 0; n < 200; n++) begin
            done = 1'b1;
            for (int p = 0; p < NB; p++) if (exp_resp_b[p].size() != 0 || pend_b[p].size() != 0) done = 1'b0;
            if (done) break;
            tick();
        end
        check("b_resp_drained", done, 1);
        tick();
        for (int p = 0; p < NB; p++) begin
            check("b_end_outstanding", out_b[p], 0);
            check("b_end_idle", idle_b[p], 1);
            check("b_end_spurious", spur_b[p], 0);
            check("b_end_req_q", exp_req_b[p].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
